// File: rtl/wm8731_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wm8731_config_sequencer
// Description : Programs the WM8731 codec over the av_config two-wire bus.
//               After reset it writes an 11-word init table; afterwards it
//               accepts single runtime register writes over a req/ack
//               handshake. Each word is sent as one write frame:
//               START, 8'h34 (device address + write), reg byte, data byte,
//               STOP, then an idle gap. A NACKed frame is retried up to
//               MAX_RETRY extra times before the sequencer parks in ERR.
// Ports       : clk            system clock
//               reset          asynchronous active-high reset
//               wr_req         runtime write request (held until wr_ack)
//               wr_word        {reg_addr[6:0], data[8:0]}
//               wr_ack         one-cycle pulse, word accepted
//               busy           init or a write frame in progress
//               init_done      sticky, init table fully ACKed
//               error          sticky, a word ran out of retries
//               av_config_SCLK bus clock, push-pull
//               av_config_SDAT bus data, open drain (0 or z only)
// Revision    : 1.0 - initial release
// ============================================================================
module wm8731_config_sequencer #(
  parameter int         CLK_FREQ_HZ = 50_000_000,
  parameter int         I2C_FREQ_HZ = 100_000,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [15:0] wr_word,
  output logic        wr_ack,
  output logic        busy,
  output logic        init_done,
  output logic        error,
  output logic        av_config_SCLK,
  inout  wire         av_config_SDAT
);

  // Clocks per quarter bit. Must be >= 2 so the ACK sample (first clock of
  // Q3) lands strictly before the bit-end decision (last clock of Q3).
  localparam int         QTR       = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int         QW        = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int         RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [QW-1:0] QTR_LAST  = QW'(QTR - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};
  localparam logic [3:0] LAST_INIT = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  function automatic logic [15:0] init_word(input logic [3:0] idx);
    case (idx)
      4'd0:    init_word = 16'h1E00;  // reset
      4'd1:    init_word = 16'h0C00;  // power down control
      4'd2:    init_word = 16'h0E02;  // digital audio interface format
      4'd3:    init_word = 16'h1000;  // sampling control
      4'd4:    init_word = 16'h0017;  // left line in
      4'd5:    init_word = 16'h0217;  // right line in
      4'd6:    init_word = 16'h0479;  // left headphone out
      4'd7:    init_word = 16'h0679;  // right headphone out
      4'd8:    init_word = 16'h0812;  // analogue audio path
      4'd9:    init_word = 16'h0A06;  // digital audio path
      default: init_word = 16'h1201;  // active control (index 10)
    endcase
  endfunction

  state_t        state, state_n;
  logic [QW-1:0] q_cnt, q_cnt_n;        // clock within the current quarter
  logic [1:0]    qtr, qtr_n;            // quarter within the current bit
  logic [2:0]    bit_cnt, bit_cnt_n;    // bit within byte, MSB first
  logic [1:0]    byte_cnt, byte_cnt_n;  // 0 = address, 1 = reg, 2 = data
  logic [3:0]    word_idx, word_idx_n;  // init table index
  logic [RW-1:0] retry, retry_n;
  logic [15:0]   rt_word, rt_word_n;    // latched runtime word
  logic          init_done_n;
  logic          wr_ack_n;
  logic          nack, nack_n;          // sampled ACK-slot level
  logic          frame_ok, frame_ok_n;  // current frame fully ACKed
  logic          give_up, give_up_n;    // retries exhausted, ERR after STOP

  logic          q_end, bit_end;
  logic [15:0]   word;
  logic [7:0]    cur_byte;
  logic          cur_bit;
  logic          sclk, sdat_low;
  logic          sdat_in;

  assign q_end   = (q_cnt == QTR_LAST);
  assign bit_end = q_end && (qtr == 2'd3);
  assign word    = init_done ? rt_word : init_word(word_idx);
  assign sdat_in = av_config_SDAT;

  always_comb begin
    cur_byte = ADDR_BYTE;
    if (byte_cnt == 2'd1)      cur_byte = word[15:8];
    else if (byte_cnt == 2'd2) cur_byte = word[7:0];
  end

  assign cur_bit = cur_byte[bit_cnt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      q_cnt     <= '0;
      qtr       <= '0;
      bit_cnt   <= 3'd7;
      byte_cnt  <= '0;
      word_idx  <= '0;
      retry     <= '0;
      rt_word   <= '0;
      init_done <= 1'b0;
      wr_ack    <= 1'b0;
      nack      <= 1'b0;
      frame_ok  <= 1'b0;
      give_up   <= 1'b0;
    end else begin
      state     <= state_n;
      q_cnt     <= q_cnt_n;
      qtr       <= qtr_n;
      bit_cnt   <= bit_cnt_n;
      byte_cnt  <= byte_cnt_n;
      word_idx  <= word_idx_n;
      retry     <= retry_n;
      rt_word   <= rt_word_n;
      init_done <= init_done_n;
      wr_ack    <= wr_ack_n;
      nack      <= nack_n;
      frame_ok  <= frame_ok_n;
      give_up   <= give_up_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_cnt_n     = q_cnt;
    qtr_n       = qtr;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    word_idx_n  = word_idx;
    retry_n     = retry;
    rt_word_n   = rt_word;
    init_done_n = init_done;
    wr_ack_n    = 1'b0;
    nack_n      = nack;
    frame_ok_n  = frame_ok;
    give_up_n   = give_up;
    sclk        = 1'b1;
    sdat_low    = 1'b0;

    // Every bus state lasts a whole number of bits, so the quarter counters
    // simply free-run and wrap to Q0 at each state change.
    if (state != S_IDLE && state != S_ERR) begin
      if (q_end) begin
        q_cnt_n = '0;
        qtr_n   = qtr + 2'd1;
      end else begin
        q_cnt_n = q_cnt + 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        q_cnt_n = '0;
        qtr_n   = '0;
        if (!init_done) begin
          state_n    = S_START;
          word_idx_n = '0;
          retry_n    = '0;
        end else if (wr_req) begin
          state_n   = S_START;
          wr_ack_n  = 1'b1;
          rt_word_n = wr_word;
          retry_n   = '0;
        end
      end

      S_START: begin
        // SDAT falls halfway through with SCLK held high.
        sdat_low = qtr[1];
        if (bit_end) begin
          state_n    = S_BIT;
          byte_cnt_n = '0;
          bit_cnt_n  = 3'd7;
          frame_ok_n = 1'b0;
        end
      end

      S_BIT: begin
        sclk     = qtr[1];
        sdat_low = !cur_bit;
        if (bit_end) begin
          if (bit_cnt == 3'd0) state_n = S_ACK;
          else                 bit_cnt_n = bit_cnt - 3'd1;
        end
      end

      S_ACK: begin
        sclk = qtr[1];
        if (qtr == 2'd3 && q_cnt == '0) nack_n = sdat_in;
        if (bit_end) begin
          if (nack) begin
            state_n = S_STOP;
            if (retry == RETRY_MAX) give_up_n = 1'b1;
            else                    retry_n   = retry + 1'b1;
          end else if (byte_cnt == 2'd2) begin
            state_n    = S_STOP;
            frame_ok_n = 1'b1;
            retry_n    = '0;
          end else begin
            state_n    = S_BIT;
            byte_cnt_n = byte_cnt + 2'd1;
            bit_cnt_n  = 3'd7;
          end
        end
      end

      S_STOP: begin
        // SDAT rises in Q3 while SCLK is high.
        sclk     = qtr[1];
        sdat_low = (qtr != 2'd3);
        if (bit_end) state_n = give_up ? S_ERR : S_GAP;
      end

      S_GAP: begin
        if (bit_end) begin
          if (!frame_ok) begin
            state_n = S_START;           // resend the same word
          end else if (!init_done) begin
            if (word_idx == LAST_INIT) begin
              state_n     = S_IDLE;
              init_done_n = 1'b1;
            end else begin
              state_n    = S_START;
              word_idx_n = word_idx + 4'd1;
            end
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      S_ERR: begin
        q_cnt_n = '0;
        qtr_n   = '0;
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE) && (state != S_ERR);
  assign error          = (state == S_ERR);
  assign av_config_SCLK = sclk;
  assign av_config_SDAT = sdat_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_wm8731_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wm8731_config_sequencer
// Description : Directed bench for wm8731_config_sequencer with QTR = 4.
//               A bus slave model decodes frames, ACKs by default and NACKs
//               chosen bytes of chosen frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm8731_config_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_word = 16'h0000;
  logic        wr_ack, busy, init_done, error, sclk;
  wire         sdat;
  logic        slave_low = 1'b0;

  pullup (sdat);
  assign sdat = slave_low ? 1'b0 : 1'bz;

  wm8731_config_sequencer #(
    .CLK_FREQ_HZ(1_600_000),
    .I2C_FREQ_HZ(100_000),
    .DEV_ADDR   (7'h1A),
    .MAX_RETRY  (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_word       (wr_word),
    .wr_ack        (wr_ack),
    .busy          (busy),
    .init_done     (init_done),
    .error         (error),
    .av_config_SCLK(sclk),
    .av_config_SDAT(sdat)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int t_rel  = 0;

  logic [15:0] exp_tab [0:10] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0017,
                                  16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A06,
                                  16'h1201};

  // bus monitor / slave state
  logic [7:0] log_b [0:63];
  int   log_n, starts, stops, scl_falls, frame_idx, bitcnt, byte_pos;
  logic [7:0] sh;
  logic prev_scl, prev_sda;
  int   nack_lo = -1, nack_hi = -2, nack_pos = 0;
  int   t_sda_fall0, t_scl_fall0, t_scl_rise0, t_scl_fall1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      log_n = 0; starts = 0; stops = 0; scl_falls = 0; frame_idx = -1;
      bitcnt = 0; byte_pos = 0; sh = 8'h00; prev_scl = 1'b1; prev_sda = 1'b1;
      slave_low = 1'b0;
      t_sda_fall0 = -1; t_scl_fall0 = -1; t_scl_rise0 = -1; t_scl_fall1 = -1;
    end else begin
      if (prev_scl && sclk && prev_sda && !sdat) begin
        starts++; frame_idx++; bitcnt = 0; byte_pos = 0;
        if (frame_idx == 0) t_sda_fall0 = cyc;
      end else if (prev_scl && sclk && !prev_sda && sdat) begin
        stops++;
      end else if (!prev_scl && sclk) begin
        if (frame_idx == 0 && t_scl_rise0 < 0) t_scl_rise0 = cyc;
        if (bitcnt < 8) sh = {sh[6:0], sdat};
        bitcnt++;
        if (bitcnt == 8 && log_n < 64) begin
          log_b[log_n] = sh;
          log_n++;
        end
      end else if (prev_scl && !sclk) begin
        scl_falls++;
        if (frame_idx == 0) begin
          if (t_scl_fall0 < 0)      t_scl_fall0 = cyc;
          else if (t_scl_fall1 < 0) t_scl_fall1 = cyc;
        end
        if (bitcnt == 8) begin
          slave_low = !(frame_idx >= nack_lo && frame_idx <= nack_hi && byte_pos == nack_pos);
        end else if (bitcnt == 9) begin
          slave_low = 1'b0; bitcnt = 0; byte_pos++;
        end
      end
      prev_scl = sclk;
      prev_sda = sdat;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_req = 1'b0;
    repeat (3) @(negedge clk);
    t_rel = cyc;
    reset = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", sclk); else passed++;
    total++; if (sdat !== 1'b1) $display("FAIL reset_sdat got %b want 1 (released)", sdat); else passed++;
    total++; if ({wr_ack, busy, init_done, error} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {wr_ack, busy, init_done, error}); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL first_clock_busy got %b want 1", busy); else passed++;
  endtask

  task automatic test_init();
    bit ok;
    nack_lo = -1; nack_hi = -2;
    do_reset();
    wait_end(12000, ok);
    total++; if (ok !== 1'b1) $display("FAIL init_timeout got 0 want 1"); else passed++;
    total++; if ({init_done, busy, error} !== 3'b100)
      $display("FAIL init_flags got %b want 100", {init_done, busy, error}); else passed++;
    total++; if (log_n !== 33) $display("FAIL init_bytes got %0d want 33", log_n); else passed++;
    for (int f = 0; f < 11; f++) begin
      total++;
      if ({log_b[3*f], log_b[3*f+1], log_b[3*f+2]} !== {8'h34, exp_tab[f]})
        $display("FAIL init_frame%0d got %h%h%h want 34%h", f, log_b[3*f], log_b[3*f+1],
                 log_b[3*f+2], exp_tab[f]);
      else passed++;
    end
    total++; if ({starts, stops} !== {32'd11, 32'd11})
      $display("FAIL init_start_stop got %0d/%0d want 11/11", starts, stops); else passed++;
    total++; if (t_sda_fall0 - t_rel !== 9)
      $display("FAIL t_release_to_start got %0d want 9", t_sda_fall0 - t_rel); else passed++;
    total++; if (t_scl_fall0 - t_sda_fall0 !== 8)
      $display("FAIL t_start_hold got %0d want 8", t_scl_fall0 - t_sda_fall0); else passed++;
    total++; if (t_scl_rise0 - t_scl_fall0 !== 8)
      $display("FAIL t_scl_low got %0d want 8", t_scl_rise0 - t_scl_fall0); else passed++;
    total++; if (t_scl_fall1 - t_scl_rise0 !== 8)
      $display("FAIL t_scl_high got %0d want 8", t_scl_fall1 - t_scl_rise0); else passed++;
  endtask

  task automatic test_nack_retry();
    bit ok;
    int seq [0:12] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 8, 9, 10};
    nack_lo = 3; nack_hi = 4; nack_pos = 2;
    do_reset();
    wait_end(12000, ok);
    total++; if ({ok, init_done, error} !== 3'b110)
      $display("FAIL retry_flags got %b want 110", {ok, init_done, error}); else passed++;
    total++; if (log_n !== 39) $display("FAIL retry_bytes got %0d want 39", log_n); else passed++;
    for (int f = 0; f < 13; f++) begin
      total++;
      if ({log_b[3*f], log_b[3*f+1], log_b[3*f+2]} !== {8'h34, exp_tab[seq[f]]})
        $display("FAIL retry_frame%0d got %h%h%h want 34%h", f, log_b[3*f], log_b[3*f+1],
                 log_b[3*f+2], exp_tab[seq[f]]);
      else passed++;
    end
    nack_lo = -1; nack_hi = -2;
  endtask

  task automatic test_runtime_write();
    int base, extra_acks;
    bit fell;
    base = log_n; extra_acks = 0; fell = 1'b0;
    @(negedge clk);
    wr_word = 16'h0460; wr_req = 1'b1;
    @(negedge clk);
    total++; if ({wr_ack, busy} !== 2'b11)
      $display("FAIL rt_ack1 got ack=%b busy=%b want 1 1", wr_ack, busy); else passed++;
    wr_word = 16'h0812;
    @(negedge clk);
    total++; if (wr_ack !== 1'b0) $display("FAIL rt_ack_width got %b want 0", wr_ack); else passed++;
    for (int i = 0; i < 2000; i++) begin
      if (wr_ack) extra_acks++;
      if (!busy) begin fell = 1'b1; break; end
      @(negedge clk);
    end
    total++; if ({fell, extra_acks[3:0]} !== 5'b10000)
      $display("FAIL rt_busy_fall got fell=%b acks=%0d want 1 0", fell, extra_acks); else passed++;
    @(negedge clk);
    total++; if ({wr_ack, busy} !== 2'b11)
      $display("FAIL rt_back_to_back got ack=%b busy=%b want 1 1", wr_ack, busy); else passed++;
    wr_req = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin fell = 1'b1; break; end
    end
    total++; if (fell !== 1'b1) $display("FAIL rt_second_done got 0 want 1"); else passed++;
    total++; if ({log_b[base], log_b[base+1], log_b[base+2], log_b[base+3], log_b[base+4],
                  log_b[base+5]} !== 48'h340460_340812)
      $display("FAIL rt_frames got %h %h %h %h %h %h want 34 04 60 34 08 12", log_b[base],
               log_b[base+1], log_b[base+2], log_b[base+3], log_b[base+4], log_b[base+5]);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok, found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_idx == 2 && byte_pos == 0 && bitcnt == 4 && !sclk) begin
        found = 1'b1;
        break;
      end
    end
    total++; if ({found, sdat} !== 2'b10)
      $display("FAIL mid_frame_reach got found=%b sdat=%b want 1 0", found, sdat); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({sclk, sdat, busy} !== 3'b110)
      $display("FAIL mid_reset_bus got %b want 110", {sclk, sdat, busy}); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_end(12000, ok);
    total++; if ({ok, init_done, log_n[7:0]} !== {2'b11, 8'd33})
      $display("FAIL mid_replay got ok=%b done=%b bytes=%0d want 1 1 33", ok, init_done, log_n);
    else passed++;
    total++; if ({log_b[0], log_b[1], log_b[2]} !== 24'h341E00)
      $display("FAIL mid_first_frame got %h%h%h want 341e00", log_b[0], log_b[1], log_b[2]);
    else passed++;
  endtask

  task automatic test_nack_error();
    bit ok;
    int falls0, acks;
    nack_lo = 5; nack_hi = 8; nack_pos = 0;
    do_reset();
    wait_end(12000, ok);
    total++; if ({ok, error, busy, init_done} !== 4'b1100)
      $display("FAIL err_flags got %b want 1100", {ok, error, busy, init_done}); else passed++;
    total++; if (log_n !== 19) $display("FAIL err_bytes got %0d want 19", log_n); else passed++;
    total++; if ({log_b[15], log_b[16], log_b[17], log_b[18]} !== 32'h34343434)
      $display("FAIL err_addr_tries got %h %h %h %h want 34 34 34 34", log_b[15], log_b[16],
               log_b[17], log_b[18]);
    else passed++;
    total++; if (stops !== 9) $display("FAIL err_stops got %0d want 9", stops); else passed++;
    falls0 = scl_falls; acks = 0;
    wr_word = 16'h0460; wr_req = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (wr_ack) acks++;
    end
    wr_req = 1'b0;
    total++; if (acks !== 0) $display("FAIL err_no_ack got %0d want 0", acks); else passed++;
    total++; if (scl_falls !== falls0)
      $display("FAIL err_bus_quiet got %0d want %0d", scl_falls, falls0); else passed++;
    total++; if ({error, sclk, sdat} !== 3'b111)
      $display("FAIL err_hold got %b want 111", {error, sclk, sdat}); else passed++;
    nack_lo = -1; nack_hi = -2;
  endtask

  initial begin
    test_reset();
    test_init();
    test_nack_retry();
    test_runtime_write();
    test_reset_mid_frame();
    test_nack_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
